// File: rtl/mini_src_control_unit.sv
// Hardwired Moore control sequencer for the Mini-SRC datapath: fetch plus per-opcode execute steps.
// Optional single-step gating is enabled by defining STEP_MODE_EN (adds the step input and WAIT).
module mini_src_control_unit #(
  parameter int unsigned OPW = 5,
  parameter int unsigned IRW = 32
) (
  input  logic           Clock,
  input  logic           clear,
`ifdef STEP_MODE_EN
  input  logic           step,
`endif
  input  logic [IRW-1:0] ir,
  input  logic           con_ff,
  input  logic           stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           LOin,
  output logic           HIin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           GRA,
  output logic           GRB,
  output logic           GRC,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           InportOut,
  output logic           OutportIn,
  output logic           CONin,
  output logic [4:0]     alu_op,
  output logic           run,
  output logic           instr_done
);

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt, StWait
  } state_e;

  localparam logic [OPW-1:0] OpLd   = 5'b00000;
  localparam logic [OPW-1:0] OpLdi  = 5'b00001;
  localparam logic [OPW-1:0] OpSt   = 5'b00010;
  localparam logic [OPW-1:0] OpAdd  = 5'b00011;
  localparam logic [OPW-1:0] OpOr   = 5'b00110;
  localparam logic [OPW-1:0] OpAddi = 5'b01100;
  localparam logic [OPW-1:0] OpAndi = 5'b01101;
  localparam logic [OPW-1:0] OpOri  = 5'b01110;
  localparam logic [OPW-1:0] OpBr   = 5'b10010;
  localparam logic [OPW-1:0] OpJr   = 5'b10011;
  localparam logic [OPW-1:0] OpIn   = 5'b10101;
  localparam logic [OPW-1:0] OpOut  = 5'b10110;
  localparam logic [OPW-1:0] OpHalt = 5'b11011;

  state_e state_q, state_d;
  logic [OPW-1:0] opcode;
  logic is_mem, is_rtype, is_imm;
  logic [4:0] imm_alu;
  logic unused_ir;

  assign opcode    = ir[IRW-1 -: OPW];
  assign unused_ir = ^ir[IRW-OPW-1:0];
  assign is_mem    = (opcode == OpLd) || (opcode == OpLdi) || (opcode == OpSt);
  // add, sub, and, or occupy a contiguous opcode range and pass straight through as alu_op
  assign is_rtype  = (opcode >= OpAdd) && (opcode <= OpOr);
  assign is_imm    = (opcode == OpAddi) || (opcode == OpAndi) || (opcode == OpOri);
  assign imm_alu   = (opcode == OpAddi) ? 5'b00011 : (opcode == OpAndi) ? 5'b00101 : 5'b00110;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_q <= StReset;
    else        state_q <= state_d;
  end

  always_comb begin
    {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, IncPC,
     Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout, InportOut, OutportIn, CONin} = '0;
    alu_op     = '0;
    run        = 1'b0;
    instr_done = 1'b0;
    state_d    = state_q;
    unique case (state_q)
`ifdef STEP_MODE_EN
      StReset: state_d = StWait;
`else
      StReset: state_d = StT0;
`endif
      StT0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        run = 1'b1;
        state_d = StT4;
        if (is_mem) begin
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_rtype || is_imm) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (opcode == OpBr) begin
          GRA = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (opcode == OpJr) begin
          GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; instr_done = 1'b1;
        end else if (opcode == OpIn) begin
          InportOut = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else if (opcode == OpOut) begin
          GRA = 1'b1; Rout = 1'b1; OutportIn = 1'b1; instr_done = 1'b1;
        end else if (opcode == OpHalt) begin
          state_d = StHalt;
        end else begin
          instr_done = 1'b1;
        end
      end
      StT4: begin
        run = 1'b1;
        state_d = StT5;
        if (is_mem) begin
          Cout = 1'b1; alu_op = 5'b00011; Zin = 1'b1;
        end else if (is_rtype) begin
          GRC = 1'b1; Rout = 1'b1; alu_op = opcode; Zin = 1'b1;
        end else if (is_imm) begin
          Cout = 1'b1; alu_op = imm_alu; Zin = 1'b1;
        end else if (opcode == OpBr) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          state_d = StT0;
        end
      end
      StT5: begin
        run = 1'b1;
        state_d = StT6;
        if (opcode == OpLd || opcode == OpSt) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (opcode == OpLdi || is_rtype || is_imm) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else if (opcode == OpBr) begin
          Cout = 1'b1; alu_op = 5'b00011; Zin = 1'b1;
        end else begin
          state_d = StT0;
        end
      end
      StT6: begin
        run = 1'b1;
        state_d = StT7;
        if (opcode == OpLd) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (opcode == OpSt) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (opcode == OpBr) begin
          Zlowout = 1'b1; PCin = con_ff; instr_done = 1'b1;
        end else begin
          state_d = StT0;
        end
      end
      StT7: begin
        run = 1'b1;
        state_d = StT0;
        if (opcode == OpLd) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else if (opcode == OpSt) begin
          Write = 1'b1; instr_done = 1'b1;
        end
      end
      StHalt: state_d = StHalt;
      StWait: begin
`ifdef STEP_MODE_EN
        run = 1'b1;
        if (stop)      state_d = StHalt;
        else if (step) state_d = StT0;
`else
        state_d = StT0;
`endif
      end
      default: state_d = StReset;
    endcase
    // stop is only looked at on the instruction boundary so a running instruction always completes
    if (instr_done) begin
`ifdef STEP_MODE_EN
      state_d = stop ? StHalt : StWait;
`else
      state_d = stop ? StHalt : StT0;
`endif
    end
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Randomized bench for mini_src_control_unit against a per-opcode control-step table model.
module tb_mini_src_control_unit;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
    logic IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout, InportOut, OutportIn, CONin;
    logic [4:0] alu_op;
    logic run;
    logic done;
  } ctl_t;

  logic Clock = 1'b0;
  logic clear, con_ff, stop;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
  logic IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout, InportOut, OutportIn, CONin;
  logic [4:0] alu_op;
  logic run, instr_done;
  ctl_t got;

  int n_checks = 0;
  int n_fail = 0;
  ctl_t exp_q[$];

  always #5 Clock = ~Clock;

  mini_src_control_unit dut (
    .Clock(Clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .MARin(MARin),
    .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .InportOut(InportOut), .OutportIn(OutportIn),
    .CONin(CONin), .alu_op(alu_op), .run(run), .instr_done(instr_done)
  );

  assign got = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
                IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout, InportOut, OutportIn,
                CONin, alu_op, run, instr_done};

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  function automatic ctl_t busy();
    ctl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  // Expected control word per step, straight from the instruction's register-transfer list.
  function automatic void build_expected(input logic [31:0] instr, input logic cf);
    logic [4:0] op = instr[31:27];
    ctl_t c;
    exp_q.delete();
    c = busy(); c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; exp_q.push_back(c);
    c = busy(); c.Zlowout = 1; c.PCin = 1; c.Read = 1; c.MDRin = 1; exp_q.push_back(c);
    c = busy(); c.MDRout = 1; c.IRin = 1; exp_q.push_back(c);
    if (op <= 5'd2) begin
      c = busy(); c.GRB = 1; c.BAout = 1; c.Yin = 1; exp_q.push_back(c);
      c = busy(); c.Cout = 1; c.alu_op = 5'd3; c.Zin = 1; exp_q.push_back(c);
      if (op == 5'd1) begin
        c = busy(); c.Zlowout = 1; c.GRA = 1; c.Rin = 1; c.done = 1; exp_q.push_back(c);
      end else begin
        c = busy(); c.Zlowout = 1; c.MARin = 1; exp_q.push_back(c);
        if (op == 5'd0) begin
          c = busy(); c.Read = 1; c.MDRin = 1; exp_q.push_back(c);
          c = busy(); c.MDRout = 1; c.GRA = 1; c.Rin = 1; c.done = 1; exp_q.push_back(c);
        end else begin
          c = busy(); c.GRA = 1; c.Rout = 1; c.MDRin = 1; exp_q.push_back(c);
          c = busy(); c.Write = 1; c.done = 1; exp_q.push_back(c);
        end
      end
    end else if ((op >= 5'd3 && op <= 5'd6) || (op >= 5'd12 && op <= 5'd14)) begin
      c = busy(); c.GRB = 1; c.Rout = 1; c.Yin = 1; exp_q.push_back(c);
      c = busy(); c.Zin = 1;
      if (op <= 5'd6) begin
        c.GRC = 1; c.Rout = 1; c.alu_op = op;
      end else begin
        c.Cout = 1;
        c.alu_op = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
      end
      exp_q.push_back(c);
      c = busy(); c.Zlowout = 1; c.GRA = 1; c.Rin = 1; c.done = 1; exp_q.push_back(c);
    end else if (op == 5'd18) begin
      c = busy(); c.GRA = 1; c.Rout = 1; c.CONin = 1; exp_q.push_back(c);
      c = busy(); c.PCout = 1; c.Yin = 1; exp_q.push_back(c);
      c = busy(); c.Cout = 1; c.alu_op = 5'd3; c.Zin = 1; exp_q.push_back(c);
      c = busy(); c.Zlowout = 1; c.PCin = cf; c.done = 1; exp_q.push_back(c);
    end else begin
      c = busy();
      case (op)
        5'd19:   begin c.GRA = 1; c.Rout = 1; c.PCin = 1; c.done = 1; end
        5'd21:   begin c.InportOut = 1; c.GRA = 1; c.Rin = 1; c.done = 1; end
        5'd22:   begin c.GRA = 1; c.Rout = 1; c.OutportIn = 1; c.done = 1; end
        5'd27:   ;
        default: c.done = 1;
      endcase
      exp_q.push_back(c);
    end
  endfunction

  // Entered #1 after the edge that starts T0; leaves #1 after the edge ending the last step.
  task automatic run_instr(input logic [31:0] instr, input logic cf, input int stop_at,
                           input int abort_at);
    ir = instr;
    con_ff = cf;
    build_expected(instr, cf);
    foreach (exp_q[i]) begin
      @(negedge Clock);
      check_eq($sformatf("op%05b_t%0d", instr[31:27], i), got, exp_q[i]);
      if (i == stop_at) stop = 1'b1;
      if (i == abort_at) begin
        #2 clear = 1'b0;
        #1 check_eq("async_clear", got, '0);
        return;
      end
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check_halted(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge Clock);
      check_eq(tag, got, '0);
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    stop = 1'b0;
    @(negedge Clock);
    check_eq("reset", got, '0);
    @(negedge Clock);
    clear = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [4:0] op;
    clear = 1'b0;
    stop = 1'b0;
    con_ff = 1'b0;
    ir = '0;
    @(negedge Clock);
    do_reset();
    run_instr(32'h01000095, 1'b0, -1, -1);
    run_instr(32'h1A920000, 1'b0, -1, -1);
    run_instr(32'h90000000, 1'b0, -1, -1);
    run_instr(32'h90000000, 1'b1, -1, -1);
    run_instr(32'h10800010, 1'b0, -1, -1);
    repeat (40) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr({op, 27'($urandom)}, 1'($urandom), -1, -1);
    end
    run_instr(32'h1A920000, 1'b1, 4, -1);
    check_halted("halt_after_stop", 20);
    do_reset();
    run_instr(32'hD8000000, 1'b0, -1, -1);
    check_halted("halt_op", 20);
    do_reset();
    run_instr(32'h01000095, 1'b0, -1, 6);
    do_reset();
    run_instr(32'h01000095, 1'b1, -1, -1);
    run_instr(32'h68400007, 1'b0, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
